aes_inv_subshift: RTL and testbench
===================================

# aes_inv_subshift

Inverse-cipher InvShiftRows + InvSubBytes stage for the AES decryption datapath. Accepts a 128-bit state over a valid/ready handshake and applies InvShiftRows. It then streams the four 32-bit columns through the 4-byte `aes_inv_sbox` word engine, which shares the external inverse-S-Box ROM. The four result words are reassembled and presented downstream over a second valid/ready handshake. The block sits between the round-key/InvMixColumns logic and `aes_inv_sbox`, and drives that engine's `sboxw` input directly.

## Interface
- `SBOX_PERIOD`, default 5: cycle period of the `aes_inv_sbox` word loop (IDLE, READ0..READ3). This is fixed by that engine and must not be changed independently.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low. The same net also resets `aes_inv_sbox`.
- `in_valid`  in  1  upstream state valid.
- `in_ready`  out  1  block can accept a state.
- `in_state`  in  128  input state. Byte n is `[127-8n -: 8]`, at row n%4, column n/4 (FIPS-197 column-major).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_state`  out  128  InvSubBytes(InvShiftRows(in_state)), same byte layout as `in_state`.
- `sboxw`  out  32  word to `aes_inv_sbox.sboxw`.
- `new_sboxw`  in  32  result from `aes_inv_sbox.new_sboxw`.
- `busy`  out  1  high in every state other than S_IDLE.

## Operation
- **Phase counter `ph`:**
  - Free-running, counts 0..SBOX_PERIOD-1 and wraps.
  - Reset value is 0.
  - `ph`=0 coincides with `aes_inv_sbox` state IDLE, `ph`=1..4 with READ0..READ3.
  - Alignment holds only because both blocks leave reset on the same edge.
- **Buffer `buf`:** on accept, `buf` <= InvShiftRows(`in_state`), computed as out[r][c] = in[r][(c-r) mod 4].
- **Word path:**
  - `sboxw` = `buf` column `wi`, where column 0 is `[127:96]`. This holds in every state.
  - `wi` is cleared on accept.
- **FSM states:**
  - **S_IDLE:** `in_ready`=1. On `in_valid`&`in_ready`, load `buf`, clear `wi`, `cc` and `first`, then go to S_ALIGN.
  - **S_ALIGN:** wait until the cycle with `ph`=4, then go to S_RUN. S_ALIGN lasts 1..5 cycles.
  - **S_RUN:**
    - In each cycle with `ph`=4 and `wi`<3, do `wi`++.
    - In each cycle with `ph`=0, except the first S_RUN cycle (flagged by `first`), do `res[cc]` <= `new_sboxw` and `cc`++.
    - After the capture with `cc`=3, go to S_DONE.
  - **S_DONE:** `out_valid`=1. On `out_ready`, go to S_IDLE.
- `out_state` = `res`, registered. It is held stable from entry to S_DONE until the next result overwrites it.
- **No overlap:** `in_ready`=0 outside S_IDLE. The next state cannot be accepted in the same cycle as the output handshake; it is accepted from S_IDLE at the earliest one cycle later.
- **Stable inputs:** `in_state` is ignored except on the accept cycle. `out_ready` is ignored except in S_DONE.

## Timing
- **Reset values:**
  - `in_ready`=1 (S_IDLE).
  - `out_valid`=0, `busy`=0.
  - `out_state`=0.
  - `sboxw`=0 (`buf`=0, `wi`=0).
  - `ph`=0.
- **Word hold:** column k is held on `sboxw` for 5 cycles, from `ph`=0 through `ph`=4 of RUN period k. This covers all four `aes_inv_sbox` address samples (IDLE, READ0, READ1, READ2).
- **Capture:** `new_sboxw` for column k is complete in the `ph`=0 cycle of period k+1 and is captured at the end of that cycle. At that point READ0 has not yet overwritten byte `[31:24]`.
- **Latency:**
  - S_RUN lasts 21 cycles; `out_valid` rises 21 cycles after the first S_RUN cycle.
  - Accept-to-`out_valid` is S_ALIGN length + 21, i.e. 22..26 cycles depending on `ph` at accept.
- **Back-pressure:** S_DONE has no time-out. `out_valid` and `out_state` are held while `out_ready`=0. `ph` keeps running, and S_ALIGN re-synchronises the next operation.
- **Reset mid-operation:** all registers return to their reset values. `aes_inv_sbox` resets on the same edge, so phase alignment is restored. The partial result is discarded and no `out_valid` is produced.

## Test plan
- **Layout check, identity ROM:** bench ROM returns `rom_data` = `rom_addr`. Apply `in_state` = 00010203_04050607_08090a0b_0c0d0e0f. Required: `out_state` = 000d0a07_04010e0b_0805020f_0c090603, with `out_valid` 22..26 cycles after accept.
- **Real inverse S-Box ROM:** all-0x63 input -> all-0x00 output. All-0x00 input -> all-0x52 output. All-0xFF input -> all-0x7D output.
- **Alignment sweep:** issue accepts at each `ph` value 0..4. Required: the result is correct every time and latency is 26, 25, 24, 23, 22 respectively.
- **Back-pressure:** hold `out_ready`=0 for 10 cycles after `out_valid`. Required: `out_state` is stable and `in_ready`=0 throughout. `out_valid` drops the cycle after `out_ready`=1, and `in_ready`=1 on that same cycle.
- **Back-to-back:** keep `in_valid` high with two different states and `out_ready` high. Required: both results are correct and in order, and the second accept occurs the cycle after the first output handshake.
- **Reset mid-S_RUN:** assert `rst_n`=0 during period 2. Required: all outputs take their reset values and no `out_valid` appears. The next operation after reset produces a correct result.

Source files
------------

// File: rtl/aes_inv_subshift_if.sv
// Valid/ready channels of aes_inv_subshift: 128-bit state in, 128-bit result out.
interface aes_inv_subshift_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/aes_inv_subshift.sv
// AES decryption InvShiftRows + InvSubBytes stage; streams the four state columns
// through the shared aes_inv_sbox word engine in lock-step with its IDLE/READ0..READ3 loop.
module aes_inv_subshift #(
  parameter int SBOX_PERIOD = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  aes_inv_subshift_if.slave bus,
  output logic [31:0]       sboxw,
  input  logic [31:0]       new_sboxw,
  output logic              busy
);
  localparam int              PH_W    = $clog2(SBOX_PERIOD);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SBOX_PERIOD - 1);
  localparam logic [PH_W-1:0] PH_ZERO = {PH_W{1'b0}};
  localparam logic [PH_W-1:0] PH_ONE  = {{(PH_W-1){1'b0}}, 1'b1};

  // One-hot so the handshake flags come straight off state flops.
  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_ALIGN = 4'b0010,
    S_RUN   = 4'b0100,
    S_DONE  = 4'b1000
  } state_t;

  state_t          state_r, state_s;
  logic [PH_W-1:0] ph_r;
  logic [127:0]    buf_r;
  logic [127:0]    res_r;
  logic [1:0]      wi_r;
  logic [1:0]      cc_r;
  logic            first_r;  // set once the first S_RUN cycle (stale new_sboxw) has passed
  logic            accept_s;
  logic            wi_inc_s;
  logic            cap_s;

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  // Next-state decode and datapath strobes
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    wi_inc_s = 1'b0;
    cap_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.in_valid) begin
          accept_s = 1'b1;
          state_s  = S_ALIGN;
        end else begin
          state_s  = S_IDLE;
        end
      end
      S_ALIGN: begin
        if (ph_r == PH_LAST) state_s = S_RUN;
        else                 state_s = S_ALIGN;
      end
      S_RUN: begin
        if (ph_r == PH_LAST && wi_r != 2'd3) wi_inc_s = 1'b1;
        else                                 wi_inc_s = 1'b0;
        if (ph_r == PH_ZERO && first_r) begin
          cap_s = 1'b1;
          if (cc_r == 2'd3) state_s = S_DONE;
          else              state_s = S_RUN;
        end else begin
          cap_s = 1'b0;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_s = S_IDLE;
        else               state_s = S_DONE;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Column wi of the shifted state drives the S-Box word bus
  always_comb begin
    sboxw = 32'd0;
    case (wi_r)
      2'd0:    sboxw = buf_r[127:96];
      2'd1:    sboxw = buf_r[95:64];
      2'd2:    sboxw = buf_r[63:32];
      2'd3:    sboxw = buf_r[31:0];
      default: sboxw = 32'd0;
    endcase
  end

  // Phase counter, FSM state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_r    <= PH_ZERO;
      state_r <= S_IDLE;
      buf_r   <= 128'd0;
      res_r   <= 128'd0;
      wi_r    <= 2'd0;
      cc_r    <= 2'd0;
      first_r <= 1'b0;
    end else begin
      ph_r    <= (ph_r == PH_LAST) ? PH_ZERO : ph_r + PH_ONE;
      state_r <= state_s;
      if (accept_s) begin
        buf_r   <= inv_shift_rows(bus.in_state);
        wi_r    <= 2'd0;
        cc_r    <= 2'd0;
        first_r <= 1'b0;
      end else begin
        if (wi_inc_s) wi_r <= wi_r + 2'd1;
        if (state_r == S_RUN) first_r <= 1'b1;
        if (cap_s) begin
          res_r[{2'd3 - cc_r, 5'd0} +: 32] <= new_sboxw;
          cc_r <= cc_r + 2'd1;
        end
      end
    end
  end

  assign bus.in_ready  = state_r[0];
  assign bus.out_valid = state_r[3];
  assign bus.out_state = res_r;
  assign busy          = ~state_r[0];
endmodule

// File: tb/tb_aes_inv_subshift.sv
// Bench for aes_inv_subshift with a behavioural aes_inv_sbox word engine and a
// scoreboard of expected results.
module tb_aes_inv_subshift;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] sboxw;
  logic [31:0] new_sboxw;
  logic        busy;

  aes_inv_subshift_if bus ();

  aes_inv_subshift #(.SBOX_PERIOD(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .sboxw     (sboxw),
    .new_sboxw (new_sboxw),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int           tests = 0;
  int           fails = 0;
  logic [127:0] exp_q[$];
  logic [7:0]   inv_tab [256];
  bit           rom_id = 1'b0;

  // ---------------- inverse S-Box table built from the forward S-Box ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'd0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'd0;
    for (int y = 1; y < 256; y++) begin
      if (x != 8'd0 && gmul(x, 8'(y)) == 8'd1) inv = 8'(y);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] rom(input logic [7:0] a);
    return rom_id ? a : inv_tab[a];
  endfunction

  // Reference: 4x4 matrix, InvShiftRows then byte-wise ROM lookup
  function automatic logic [127:0] model(input logic [127:0] s);
    logic [7:0]   m [4][4];
    logic [127:0] o;
    for (int n = 0; n < 16; n++) m[n % 4][n / 4] = s[127 - 8*n -: 8];
    o = 128'd0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127 - 8*(4*c + r) -: 8] = rom(m[r][(c + 4 - r) % 4]);
    return o;
  endfunction

  // ---------------- behavioural aes_inv_sbox: IDLE, READ0..READ3 ----------------
  int         st;
  logic [7:0] addr_q;
  logic [31:0] nw;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= 0; addr_q <= 8'd0; nw <= 32'd0;
    end else begin
      case (st)
        0: addr_q <= sboxw[31:24];
        1: begin nw[31:24] <= rom(addr_q); addr_q <= sboxw[23:16]; end
        2: begin nw[23:16] <= rom(addr_q); addr_q <= sboxw[15:8];  end
        3: begin nw[15:8]  <= rom(addr_q); addr_q <= sboxw[7:0];   end
        default: nw[7:0] <= rom(addr_q);
      endcase
      st <= (st == 4) ? 0 : st + 1;
    end
  end
  assign new_sboxw = nw;

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [127:0] s, input int target, output int ph_acc);
    int n;
    n = 0;
    @(negedge clk);
    while ((bus.in_ready !== 1'b1 || (target >= 0 && st != (target + 4) % 5)) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 128'(bus.in_ready), 128'd1);
    bus.in_state = s;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    ph_acc = st;
    bus.in_valid = 1'b0;
    bus.in_state = ~s;
    exp_q.push_back(model(s));
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic pop_check(input string tag);
    logic [127:0] exp;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
    check({tag, "_state"}, bus.out_state, exp);
  endtask

  task automatic collect(input string tag, input int exp_lat, input int hold);
    int lat;
    logic [127:0] held;
    wait_valid(lat);
    check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    held = (exp_q.size() > 0) ? exp_q[0] : 128'hx;
    pop_check(tag);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_state"}, bus.out_state, held);
      check({tag, "_hold_inready"}, 128'(bus.in_ready), 128'd0);
      check({tag, "_hold_valid"}, 128'(bus.out_valid), 128'd1);
    end
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1; bus.out_ready = 1'b0;
    check({tag, "_valid_drop"}, 128'(bus.out_valid), 128'd0);
    check({tag, "_inready_back"}, 128'(bus.in_ready), 128'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 128'(bus.in_ready), 128'd1);
    check({tag, "_out_valid"}, 128'(bus.out_valid), 128'd0);
    check({tag, "_busy"}, 128'(busy), 128'd0);
    check({tag, "_out_state"}, bus.out_state, 128'd0);
    check({tag, "_sboxw"}, 128'(sboxw), 128'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int ph, ph_b, lat, nvalid;
    logic [127:0] sa, sb;
    bus.in_valid  = 1'b0;
    bus.in_state  = 128'd0;
    bus.out_ready = 1'b0;
    for (int x = 0; x < 256; x++) inv_tab[sbox_fwd(8'(x))] = 8'(x);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_outputs("reset");

    // layout with identity ROM
    rom_id = 1'b1;
    accept(128'h00010203_04050607_08090a0b_0c0d0e0f, -1, ph);
    check("layout_busy", 128'(busy), 128'd1);
    collect("layout", 26 - ph, 0);
    check("layout_const", bus.out_state, 128'h000d0a07_04010e0b_0805020f_0c090603);
    rom_id = 1'b0;

    // real inverse S-Box spot values
    accept({16{8'h63}}, -1, ph);
    collect("rom63", 26 - ph, 0);
    check("rom63_const", bus.out_state, {16{8'h00}});
    accept({16{8'h00}}, -1, ph);
    collect("rom00", 26 - ph, 0);
    check("rom00_const", bus.out_state, {16{8'h52}});
    accept({16{8'hff}}, -1, ph);
    collect("romff", 26 - ph, 0);
    check("romff_const", bus.out_state, {16{8'h7d}});

    // alignment sweep: latency 26..22 for phase 0..4
    for (int t = 0; t < 5; t++) begin
      accept({$urandom, $urandom, $urandom, $urandom}, t, ph);
      check("sweep_phase", 128'(ph), 128'(t));
      collect("sweep", 26 - t, 0);
    end

    // back-pressure for 10 cycles
    accept({$urandom, $urandom, $urandom, $urandom}, -1, ph);
    collect("bp", 26 - ph, 10);

    // back-to-back with in_valid and out_ready held high
    sa = {$urandom, $urandom, $urandom, $urandom};
    sb = {$urandom, $urandom, $urandom, $urandom};
    bus.in_state  = sa;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    ph = st;
    exp_q.push_back(model(sa));
    bus.in_state = sb;
    wait_valid(lat);
    check("b2b_a_latency", 128'(lat), 128'(26 - ph));
    pop_check("b2b_a");
    @(posedge clk); #1;
    check("b2b_handshake_valid", 128'(bus.out_valid), 128'd0);
    check("b2b_handshake_inready", 128'(bus.in_ready), 128'd1);
    @(posedge clk); #1;
    ph_b = st;
    check("b2b_second_accept", 128'(busy), 128'd1);
    exp_q.push_back(model(sb));
    bus.in_valid = 1'b0;
    wait_valid(lat);
    check("b2b_b_latency", 128'(lat), 128'(26 - ph_b));
    pop_check("b2b_b");
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("b2b_b_drop", 128'(bus.out_valid), 128'd0);

    // reset during RUN period 2
    accept({$urandom, $urandom, $urandom, $urandom}, -1, ph);
    repeat (5 - ph + 12) @(posedge clk);
    #1;
    check("midrst_busy_before", 128'(busy), 128'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) nvalid++;
    end
    check("midrst_no_valid", 128'(nvalid), 128'd0);
    accept({$urandom, $urandom, $urandom, $urandom}, -1, ph);
    collect("after_rst", 26 - ph, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
